gp_regfile_sb: RTL and testbench
================================

// Module: gp_regfile_sb
// PURPOSE
//  Parametrised MIPS general-purpose register file for the pipelined core. Provides NUM_RD
//  asynchronous read ports, one main writeback port and one dedicated link port (JAL -> $ra).
//  Adds a per-register pending-write scoreboard so decode can detect RAW hazards and stall.
//  Sits between decode (reads and issue) and writeback (writes).
// PARAMETERS
//  DW        32          data width
//  AW        5           address width; register count NREG = 2**AW
//  NUM_RD    2           number of read ports (>=1)
//  CNT_W     2           pending-counter width; at most 2**CNT_W-1 in-flight writes per register
//  LINK_REG  31          register written by the link port
//  GP_REG    28          register reset to GP_INIT
//  GP_INIT   32'h10008000  reset value of GP_REG
//  SP_REG    29          register reset to SP_INIT
//  SP_INIT   32'h7fffeffc  reset value of SP_REG
// PORTS
//  clk       in   1            clock; all state updates on its rising edge
//  rst       in   1            reset, synchronous, active-high
//  rd_addr   in   NUM_RD*AW    packed read addresses; port i = [i*AW +: AW]
//  rd_data   out  NUM_RD*DW    packed read data; port i = [i*DW +: DW]
//  rd_busy   out  NUM_RD       port i address has pending count != 0
//  wr_en     in   1            main writeback strobe
//  wr_addr   in   AW           main writeback register
//  wr_data   in   DW           main writeback data
//  lnk_en    in   1            link writeback strobe (targets LINK_REG)
//  lnk_data  in   DW           link writeback data
//  iss_en    in   1            issue strobe: the instruction will later write iss_addr
//  iss_addr  in   AW           destination of the issued instruction
//  iss_rdy   out  1            pending count of iss_addr < max; issue accepted only when high
//  flush     in   1            clear all pending counters (pipeline flush)
//  sb_err    out  1            sticky: a writeback arrived for a register with pending count 0
// BEHAVIOUR
//  - Reset (rst=1 at posedge): all registers 0 except GP_REG=GP_INIT, SP_REG=SP_INIT; all pending
//    counters 0; sb_err=0. After reset: rd_busy=0, iss_rdy=1, rd_data=reset contents.
//  - Register 0 reads as 0 always; writes to it are dropped; it is never busy; issue to it is a no-op.
//  - Reads are combinational (0-cycle latency) from stored state; rd_busy is combinational from
//    the registered counters.
//  - Writes take effect at the next posedge. wr_en and lnk_en both to LINK_REG in one cycle:
//    lnk_data wins.
//  - Scoreboard per register r, counter pend[r]:
//      inc = iss_en & iss_rdy & (iss_addr==r); dec = (wr_en & wr_addr==r) + (lnk_en & r==LINK_REG)
//      pend[r] <= pend[r] + inc - dec, evaluated together (issue+writeback same reg same cycle:
//      net change inc-dec).
//      dec greater than pend[r]+inc: counter clamps at 0 and sb_err sets (cleared only by rst).
//      Counter never exceeds max: iss_rdy=0 when pend[iss_addr]==2**CNT_W-1; iss_en then ignored.
//  - flush=1: all counters <= 0 that cycle; any simultaneous issue is discarded; writes in the
//    same cycle still update register data and do not set sb_err.
//  - rst overrides everything, including mid-writeback and mid-flush cycles.
// CONFIGURATION
//  GPR_BYPASS_EN defined: rd_data forwards same-cycle write data when rd_addr matches an active
//    write (lnk over wr; address 0 never forwarded); rd_busy for that port is 0 when the
//    forwarded write drives pend[r] from 1 to 0.
//  GPR_BYPASS_EN undefined: no forwarding; new value visible one cycle after the write;
//    rd_busy purely from registered counters.
// TESTING
//  1 rst=1 one cycle -> rd of r28=32'h10008000, r29=32'h7fffeffc, r5=0; rd_busy=0; iss_rdy=1; sb_err=0.
//  2 wr r0<=32'hDEADBEEF; wr r7<=32'h12345678 -> r0 reads 0; r7 reads 32'h12345678 next cycle
//    (same cycle too with GPR_BYPASS_EN).
//  3 wr_en r31<=32'h1 and lnk_en lnk_data=32'h400020 same cycle -> r31 reads 32'h400020.
//  4 issue r9 three times (CNT_W=2) -> rd_busy on r9=1, iss_rdy=0 for r9; 4th issue ignored;
//    three writebacks -> busy clears after third; sb_err stays 0.
//  5 writeback r4 with pend[r4]=0 -> sb_err=1, stays 1 until rst; data still written.
//  6 issue r3, r8 then flush with simultaneous iss_en r12 -> all busy=0, r12 not busy; rst mid-run restores case 1 values.

Source files
------------

// File: rtl/gp_regfile_sb.sv
// MIPS general-purpose register file with async reads, writeback + link write ports and a
// per-register pending-write scoreboard for RAW stalls. Optional macro GPR_BYPASS_EN forwards same-cycle writes.
module gp_regfile_sb #(
    parameter int             DW       = 32,
    parameter int             AW       = 5,
    parameter int             NUM_RD   = 2,
    parameter int             CNT_W    = 2,
    parameter int             LINK_REG = 31,
    parameter int             GP_REG   = 28,
    parameter logic [DW-1:0]  GP_INIT  = DW'(32'h10008000),
    parameter int             SP_REG   = 29,
    parameter logic [DW-1:0]  SP_INIT  = DW'(32'h7fffeffc)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    output logic [NUM_RD*DW-1:0] rd_data,
    output logic [NUM_RD-1:0]    rd_busy,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [DW-1:0]        wr_data,
    input  logic                 lnk_en,
    input  logic [DW-1:0]        lnk_data,
    input  logic                 iss_en,
    input  logic [AW-1:0]        iss_addr,
    output logic                 iss_rdy,
    input  logic                 flush,
    output logic                 sb_err
);

    localparam int               NREG    = 2**AW;
    localparam int               SW      = CNT_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [AW-1:0]    LINK_A  = AW'(LINK_REG);

    logic [DW-1:0]    regs     [NREG];
    logic [CNT_W-1:0] pend     [NREG];
    logic [CNT_W-1:0] pend_nxt [NREG];
    logic [SW-1:0]    base     [NREG];
    logic [SW-1:0]    dec      [NREG];
    logic [NREG-1:0]  inc_v;
    logic [NREG-1:0]  wr_v;
    logic [NREG-1:0]  lnk_v;
    logic [NREG-1:0]  under;
    logic             iss_go;

    function automatic logic [DW-1:0] init_val(input int r);
        if (r == GP_REG)      return GP_INIT;
        else if (r == SP_REG) return SP_INIT;
        else                  return '0;
    endfunction

    assign iss_rdy = (pend[iss_addr] != CNT_MAX);
    assign iss_go  = iss_en & iss_rdy & ~flush & (iss_addr != '0);

    // Register 0 is excluded from every decode so it never counts, never errors, never stores.
    always_comb begin
        inc_v = '0;
        wr_v  = '0;
        lnk_v = '0;
        for (int r = 1; r < NREG; r++) begin
            inc_v[r] = iss_go & (iss_addr == AW'(r));
            wr_v[r]  = wr_en  & (wr_addr  == AW'(r));
            lnk_v[r] = lnk_en & (LINK_A   == AW'(r));
        end
    end

    // Issue and writeback net together; a decrement past zero clamps and flags an underflow.
    always_comb begin
        under = '0;
        for (int r = 0; r < NREG; r++) begin
            base[r]     = {1'b0, pend[r]} + SW'(inc_v[r]);
            dec[r]      = SW'(wr_v[r]) + SW'(lnk_v[r]);
            under[r]    = (dec[r] > base[r]);
            pend_nxt[r] = '0;
            if (!flush && !under[r]) begin
                pend_nxt[r] = CNT_W'(base[r] - dec[r]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= init_val(r);
                pend[r] <= '0;
            end
            sb_err <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (lnk_v[r]) begin
                    regs[r] <= lnk_data;
                end else if (wr_v[r]) begin
                    regs[r] <= wr_data;
                end
                pend[r] <= pend_nxt[r];
            end
            if (!flush && (|under)) begin
                sb_err <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0] a;
        logic [DW-1:0] stored;
        logic          pend_nz;

        assign a       = rd_addr[i*AW +: AW];
        assign stored  = (a == '0) ? '0 : regs[a];
        assign pend_nz = (pend[a] != '0);

`ifdef GPR_BYPASS_EN
        logic fwd_l;
        logic fwd_w;
        logic drains;

        assign fwd_l  = lnk_en & (a == LINK_A) & (a != '0);
        assign fwd_w  = wr_en & (wr_addr == a) & (a != '0);
        // Busy drops only when the write seen this cycle retires the last outstanding issue.
        assign drains = (fwd_l | fwd_w) & (pend[a] == CNT_W'(1)) & (pend_nxt[a] == '0);

        assign rd_data[i*DW +: DW] = fwd_l ? lnk_data : (fwd_w ? wr_data : stored);
        assign rd_busy[i]          = pend_nz & ~drains;
`else
        assign rd_data[i*DW +: DW] = stored;
        assign rd_busy[i]          = pend_nz;
`endif
    end

endmodule

// File: tb/tb_gp_regfile_sb.sv
// Self-checking bench for gp_regfile_sb: directed cases with literal expectations, then random
// traffic compared every cycle against an array/counter model of the register file and scoreboard.
module tb_gp_regfile_sb;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NR   = 2;
    localparam int MAXP = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*DW-1:0]  rd_data;
    logic [NR-1:0]     rd_busy;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              lnk_en;
    logic [DW-1:0]     lnk_data;
    logic              iss_en;
    logic [AW-1:0]     iss_addr;
    logic              iss_rdy;
    logic              flush;
    logic              sb_err;

    gp_regfile_sb dut (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .lnk_en   (lnk_en),
        .lnk_data (lnk_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .iss_rdy  (iss_rdy),
        .flush    (flush),
        .sb_err   (sb_err)
    );

    // clock / reset
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    bit          check_en = 1'b0;
    logic [31:0] m_regs [32];
    int          m_pend [32];
    bit          m_err;
    int          nx [32];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // model: pending count after this edge (negative means more writebacks than outstanding issues)
    function automatic int model_next(input int r);
        int inc;
        int dcr;
        if (flush || r == 0) return 0;
        inc = (iss_en && iss_addr == r && m_pend[r] < MAXP) ? 1 : 0;
        dcr = ((wr_en && wr_addr == r) ? 1 : 0) + ((lnk_en && r == 31) ? 1 : 0);
        return m_pend[r] + inc - dcr;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [AW-1:0] a);
        if (a == 0) return 32'h0;
`ifdef GPR_BYPASS_EN
        if (lnk_en && a == 31) return lnk_data;
        if (wr_en && wr_addr == a) return wr_data;
`endif
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        if (m_pend[a] == 0) return 1'b0;
`ifdef GPR_BYPASS_EN
        if (((lnk_en && a == 31) || (wr_en && wr_addr == a)) && m_pend[a] == 1 && model_next(a) <= 0)
            return 1'b0;
`endif
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                m_regs[r] = 32'h0;
                m_pend[r] = 0;
            end
            m_regs[28] = 32'h10008000;
            m_regs[29] = 32'h7fffeffc;
            m_err = 1'b0;
        end else begin
            for (int r = 0; r < 32; r++) nx[r] = model_next(r);
            for (int r = 0; r < 32; r++) begin
                if (nx[r] < 0) begin
                    m_err     = 1'b1;
                    m_pend[r] = 0;
                end else begin
                    m_pend[r] = nx[r];
                end
            end
            if (wr_en && wr_addr != 0) m_regs[wr_addr] = wr_data;
            if (lnk_en) m_regs[31] = lnk_data;
        end
    end

    // scoreboard compare, away from the active edge
    always @(negedge clk) begin
        if (check_en) begin
            for (int i = 0; i < NR; i++) begin
                check($sformatf("rd_data%0d", i), rd_data[i*DW +: DW], exp_rd(rd_addr[i*AW +: AW]));
                check($sformatf("rd_busy%0d", i), 32'(rd_busy[i]), 32'(exp_busy(rd_addr[i*AW +: AW])));
            end
            check("iss_rdy", 32'(iss_rdy), 32'(m_pend[iss_addr] < MAXP));
            check("sb_err", 32'(sb_err), 32'(m_err));
        end
    end

    // driver tasks
    task automatic idle();
        wr_en = 1'b0; lnk_en = 1'b0; iss_en = 1'b0; flush = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr = {a1, a0};
        #1;
    endtask

    task automatic issue(input logic [AW-1:0] a);
        idle();
        iss_en = 1'b1; iss_addr = a;
        tick();
        idle();
    endtask

    task automatic wb(input logic [AW-1:0] a, input logic [DW-1:0] d);
        idle();
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        idle();
    endtask

    function automatic logic [AW-1:0] ra();
        case ($urandom_range(0, 5))
            0: return 5'd0;
            1: return 5'd1;
            2: return 5'd2;
            3: return 5'd31;
            default: return AW'($urandom_range(0, 31));
        endcase
    endfunction

    initial begin
        idle();
        rst = 1'b1; rd_addr = '0; wr_addr = '0; wr_data = '0; lnk_data = '0; iss_addr = '0;
        tick();
        check_en = 1'b1;
        rst = 1'b0;

        // reset contents
        set_rd(28, 29);
        check("rst_r28", rd_data[31:0], 32'h10008000);
        check("rst_r29", rd_data[63:32], 32'h7fffeffc);
        set_rd(5, 0);
        check("rst_r5", rd_data[31:0], 32'h0);
        check("rst_busy", 32'(rd_busy), 32'h0);
        check("rst_rdy", 32'(iss_rdy), 32'h1);
        check("rst_err", 32'(sb_err), 32'h0);

        // r0 is hardwired, r7 takes its write
        wb(0, 32'hDEADBEEF);
        issue(7);
        wb(7, 32'h12345678);
        set_rd(0, 7);
        check("r0_zero", rd_data[31:0], 32'h0);
        check("r7_data", rd_data[63:32], 32'h12345678);
        check("r7_err", 32'(sb_err), 32'h0);

        // link beats main writeback on $ra
        issue(31);
        issue(31);
        wr_en = 1'b1; wr_addr = 31; wr_data = 32'h1;
        lnk_en = 1'b1; lnk_data = 32'h400020;
        tick();
        idle();
        set_rd(31, 0);
        check("ra_link", rd_data[31:0], 32'h400020);
        check("ra_busy", 32'(rd_busy[0]), 32'h0);
        check("ra_err", 32'(sb_err), 32'h0);

        // saturate r9, overflow issue is ignored
        issue(9); issue(9); issue(9);
        iss_addr = 9;
        set_rd(9, 0);
        check("r9_busy_full", 32'(rd_busy[0]), 32'h1);
        check("r9_rdy_full", 32'(iss_rdy), 32'h0);
        issue(9);
        wb(9, 32'h9); wb(9, 32'h99);
        set_rd(9, 0);
        check("r9_busy_2wb", 32'(rd_busy[0]), 32'h1);
        wb(9, 32'h999);
        set_rd(9, 0);
        check("r9_busy_3wb", 32'(rd_busy[0]), 32'h0);
        check("r9_err", 32'(sb_err), 32'h0);
        check("r9_data", rd_data[31:0], 32'h999);

        // unexpected writeback is sticky but still stored
        wb(4, 32'hAAAA5555);
        set_rd(4, 0);
        check("r4_err", 32'(sb_err), 32'h1);
        check("r4_data", rd_data[31:0], 32'hAAAA5555);
        tick(); tick();
        check("r4_err_sticky", 32'(sb_err), 32'h1);

        // flush discards pending and the simultaneous issue
        issue(3); issue(8);
        set_rd(3, 8);
        check("pre_flush_busy", 32'(rd_busy), 32'h3);
        flush = 1'b1; iss_en = 1'b1; iss_addr = 12;
        tick();
        idle();
        set_rd(3, 8);
        check("flush_busy", 32'(rd_busy), 32'h0);
        set_rd(12, 0);
        check("flush_r12", 32'(rd_busy[0]), 32'h0);

        // reset overrides a concurrent write
        wr_en = 1'b1; wr_addr = 5; wr_data = 32'h5555;
        rst = 1'b1;
        tick();
        idle();
        rst = 1'b0;
        set_rd(5, 28);
        check("rst2_r5", rd_data[31:0], 32'h0);
        check("rst2_r28", rd_data[63:32], 32'h10008000);
        check("rst2_err", 32'(sb_err), 32'h0);

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            rst      = ($urandom_range(0, 299) == 0);
            flush    = ($urandom_range(0, 39) == 0);
            iss_en   = ($urandom_range(0, 1) == 0);
            iss_addr = ra();
            wr_en    = ($urandom_range(0, 3) == 0);
            wr_addr  = ra();
            wr_data  = $urandom;
            lnk_en   = ($urandom_range(0, 7) == 0);
            lnk_data = $urandom;
            rd_addr  = {ra(), ra()};
            tick();
        end
        idle();
        rst = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
